adder_seq_32bit: RTL and testbench

ADDER_SEQ_32BIT -- requirements
Module: adder_seq_32bit

---
 rtl/adder_seq_32bit.sv | 110 +++++++++++
 tb/tb_adder_seq_32bit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_32bit.sv
// Sequential 32-bit adder, SLICE_W bits per cycle (LSB slice first); sum is valid N=32/SLICE_W cycles after the accept edge.
// Result and out_valid hold until out_ready; in_ready only in IDLE. Optional cout port under ADDER_SEQ_COUT_EN.
module adder_seq_32bit #(
   parameter int SLICE_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum
`ifdef ADDER_SEQ_COUT_EN
   ,
   output logic        cout
`endif
);

   localparam int N      = 32 / SLICE_W;
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int SL_LOG = $clog2(SLICE_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_sum;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_out_valid;
`ifdef ADDER_SEQ_COUT_EN
   logic               r_cout;
`endif

   logic [4:0]         w_off;
   logic [SLICE_W-1:0] w_a_sl;
   logic [SLICE_W-1:0] w_b_sl;
   logic [SLICE_W:0]   w_sl_sum;

   // Bit offset of the current slice: idx * SLICE_W, always fits in 5 bits.
   assign w_off    = {r_idx, {SL_LOG{1'b0}}};
   assign w_a_sl   = r_a[w_off +: SLICE_W];
   assign w_b_sl   = r_b[w_off +: SLICE_W];
   assign w_sl_sum = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_W{1'b0}}, r_carry};

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
`ifdef ADDER_SEQ_COUT_EN
   assign cout      = r_cout;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef ADDER_SEQ_COUT_EN
         r_cout      <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_idx   <= '0;
                  r_carry <= 1'b0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_sum[w_off +: SLICE_W] <= w_sl_sum[SLICE_W-1:0];
               r_carry                 <= w_sl_sum[SLICE_W];
               r_idx                   <= r_idx + 1'b1;
               if (r_idx == IDX_W'(N - 1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
`ifdef ADDER_SEQ_COUT_EN
                  r_cout      <= w_sl_sum[SLICE_W];
`endif
               end
            end
            DONE: begin
               // No accept on the handshake edge: IDLE must be visited first.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_32bit.sv
// Self-checking bench for adder_seq_32bit: default SLICE_W=8 instance plus a SLICE_W=16 instance.
module tb_adder_seq_32bit;

   localparam int SW  = 8;
   localparam int N   = 32 / SW;
   localparam int N16 = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [31:0] a, b;
   logic        in_ready, out_valid;
   logic [31:0] sum;
   logic        in_valid_16, out_ready_16;
   logic [31:0] a_16, b_16;
   logic        in_ready_16, out_valid_16;
   logic [31:0] sum_16;
`ifdef ADDER_SEQ_COUT_EN
   logic        cout, cout_16;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_seq_32bit #(.SLICE_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef ADDER_SEQ_COUT_EN
      , .cout(cout)
`endif
   );

   adder_seq_32bit #(.SLICE_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
      .a(a_16), .b(b_16), .out_valid(out_valid_16), .out_ready(out_ready_16), .sum(sum_16)
`ifdef ADDER_SEQ_COUT_EN
      , .cout(cout_16)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge after the output handshake.
   // During DONE, in_valid=1 with a=0x12345678 is driven to prove it is ignored.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input int hold);
      logic [32:0] exp_full;
      exp_full = {1'b0, ta} + {1'b0, tb_v};
      check1("in_ready_before_accept", in_ready, 1'b1);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb_v;
      out_ready = 1'($urandom);
      @(negedge clk);
      check1("out_valid_after_accept", out_valid, 1'b0);
      check1("in_ready_after_accept", in_ready, 1'b0);
      for (int k = 1; k <= N; k++) begin
         in_valid  = 1'($urandom);
         a         = $urandom;
         b         = $urandom;
         out_ready = 1'($urandom);
         @(negedge clk);
         check1("out_valid_latency", out_valid, (k == N));
      end
      check("sum", sum, exp_full[31:0]);
`ifdef ADDER_SEQ_COUT_EN
      check1("cout", cout, exp_full[32]);
`endif
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         a         = 32'h12345678;
         b         = $urandom;
         @(negedge clk);
         check1("bp_out_valid", out_valid, 1'b1);
         check1("bp_in_ready", in_ready, 1'b0);
         check("bp_sum_stable", sum, exp_full[31:0]);
`ifdef ADDER_SEQ_COUT_EN
         check1("bp_cout_stable", cout, exp_full[32]);
`endif
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 32'h12345678;
      @(negedge clk);
      check1("hs_out_valid_clear", out_valid, 1'b0);
      check1("hs_in_ready_idle", in_ready, 1'b1);
      check("idle_sum_hold", sum, exp_full[31:0]);
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
   endtask

   task automatic do_op16(input logic [31:0] ta, input logic [31:0] tb_v);
      logic [32:0] exp_full;
      exp_full     = {1'b0, ta} + {1'b0, tb_v};
      in_valid_16  = 1'b1;
      a_16         = ta;
      b_16         = tb_v;
      out_ready_16 = 1'b1;
      @(negedge clk);
      in_valid_16 = 1'b0;
      a_16        = $urandom;
      check1("w16_out_valid_accept", out_valid_16, 1'b0);
      for (int k = 1; k <= N16; k++) begin
         @(negedge clk);
         check1("w16_out_valid_latency", out_valid_16, (k == N16));
      end
      check("w16_sum", sum_16, exp_full[31:0]);
`ifdef ADDER_SEQ_COUT_EN
      check1("w16_cout", cout_16, exp_full[32]);
`endif
      @(negedge clk);
      check1("w16_hs_clear", out_valid_16, 1'b0);
   endtask

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b1;
      out_ready    = 1'b0;
      a            = 32'hDEADBEEF;
      b            = 32'h1;
      in_valid_16  = 1'b0;
      out_ready_16 = 1'b1;
      a_16         = '0;
      b_16         = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_sum", sum, 32'h0);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_in_ready", in_ready, 1'b1);
`ifdef ADDER_SEQ_COUT_EN
      check1("rst_cout", cout, 1'b0);
`endif
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check1("idle_no_accept", in_ready, 1'b1);

      do_op(32'h3, 32'h5, 0);
      do_op(32'h00FF00FF, 32'h00010001, 1);
      do_op(32'hFFFFFFFF, 32'h00000001, 0);
      do_op(32'hFFFFFFFF, 32'h00000002, 2);
      do_op(32'h0F0F0F0F, 32'h01010101, 5);
      do_op(32'h12345678, 32'h11111111, 0);

      // Reset after two slices: aborts with no out_valid pulse.
      in_valid = 1'b1;
      a        = 32'hFFFFFFFF;
      b        = 32'hFFFFFFFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_sum", sum, 32'h0);
      check1("midrst_out_valid", out_valid, 1'b0);
      check1("midrst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < N + 2; k++) begin
         @(negedge clk);
         check1("midrst_no_pulse", out_valid, 1'b0);
      end
      do_op(32'h10, 32'h20, 0);

      for (int i = 0; i < 24; i++) begin
         do_op($urandom, $urandom, int'($urandom_range(0, 3)));
      end

      do_op16(32'h0000FFFF, 32'h00000001);
      do_op16(32'hFFFFFFFF, 32'h00000001);
      for (int i = 0; i < 6; i++) begin
         do_op16($urandom, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
